// File: rtl/div_iterative.sv
`default_nettype none
// ============================================================================
// div_iterative -- restoring integer divider, one quotient bit per cycle,
// signed/unsigned, start/done handshake.                        Rev 1.0
// ============================================================================
module div_iterative #(
  parameter int WORD_WIDTH = 36
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sign,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] Q,
  output logic [WORD_WIDTH-1:0] R,
  output logic                  div_by_zero
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  aorig_q, aorig_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          bzero_q, bzero_d;
  logic [W-1:0]  qout_q, qout_d;
  logic [W-1:0]  rout_q, rout_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_a_mag;
  logic [W-1:0]  w_b_mag;
  logic [W:0]    w_shift;
  logic [W:0]    w_trial;
  logic          w_ge;

  // Magnitudes: negating the most-negative value yields 2^(W-1), which is
  // exactly the right unsigned magnitude.
  assign w_a_neg = sign & A[W-1];
  assign w_b_neg = sign & B[W-1];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  // The quotient register doubles as the dividend shifter: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  assign w_shift = {rem_q, quo_q[W-1]};
  assign w_trial = w_shift - {1'b0, dvs_q};
  assign w_ge    = ~w_trial[W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    aorig_d = aorig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_RUN;
          cnt_d   = c_CNT_LAST;
          rem_d   = '0;
          quo_d   = w_a_mag;
          dvs_d   = w_b_mag;
          aorig_d = A;
          qneg_d  = w_a_neg ^ w_b_neg;
          rneg_d  = w_a_neg;
          bzero_d = (B == '0);
        end
      end

      c_RUN: begin
        // A failed trial means the shifted value is below the divisor, so its
        // top bit is zero and it fits back into W bits.
        rem_d = w_ge ? w_trial[W-1:0] : {rem_q[W-2:0], quo_q[W-1]};
        quo_d = {quo_q[W-2:0], w_ge};
        if (cnt_q == c_CNT_ZERO) begin
          state_d = c_FIX;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end

      c_FIX: begin
        state_d = c_IDLE;
        done_d  = 1'b1;
        if (bzero_q) begin
          qout_d = '1;
          rout_d = aorig_q;
          dbz_d  = 1'b1;
        end else begin
          qout_d = qneg_q ? -quo_q : quo_q;
          rout_d = rneg_q ? -rem_q : rem_q;
          dbz_d  = 1'b0;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      aorig_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      aorig_q <= aorig_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != c_IDLE);
  assign done        = done_q;
  assign Q           = qout_q;
  assign R           = rout_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iterative.sv
`default_nettype none
// ============================================================================
// tb_div_iterative -- directed vectors for div_iterative at WORD_WIDTH=8.
// Rev 1.0
// ============================================================================
module tb_div_iterative;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         sign;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  div_iterative #(.WORD_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .sign        (sign),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts in the current cycle t, checks busy/done each cycle, and returns
  // in the done cycle t+W+2 after checking the results.
  task automatic run_op(input string tag, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez, input logic hold);
    sign  = sg;
    A     = a;
    B     = b;
    start = 1'b1;
    step();
    if (hold) begin
      sign = ~sg;
      A    = a ^ 8'h5A;
      B    = b + 8'd1;
    end else begin
      start = 1'b0;
    end
    for (int k = 1; k <= W + 1; k++) begin
      check($sformatf("%s busy/done @t+%0d", tag, k), {30'd0, busy, done}, 32'd2);
      step();
    end
    start = 1'b0;
    check({tag, " busy/done @done"}, {30'd0, busy, done}, 32'd1);
    check({tag, " Q"}, {24'd0, Q}, {24'd0, eq});
    check({tag, " R"}, {24'd0, R}, {24'd0, er});
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  logic seen_done;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    A     = '0;
    B     = '0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset Q", {24'd0, Q}, 32'd0);
    check("reset R", {24'd0, R}, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    step();

    run_op("u200/7", 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    repeat (3) step();
    check("hold done", {31'd0, done}, 32'd0);
    check("hold Q", {24'd0, Q}, 32'd28);
    check("hold R", {24'd0, R}, 32'd4);

    run_op("s-7/2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0);
    step();
    run_op("s7/-2", 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);
    step();
    run_op("u/0", 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0);
    step();
    run_op("s/0", 1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0);
    step();
    run_op("s ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
    step();
    run_op("u80/FF", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
    step();
    run_op("busy-start", 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
    // Next op starts in the done cycle of the previous one.
    run_op("b2b 9/3", 1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    step();

    // Abort mid-divide: reset sampled at the end of cycle t+5.
    sign  = 1'b0;
    A     = 8'd100;
    B     = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort Q", {24'd0, Q}, 32'd0);
    check("abort R", {24'd0, R}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    run_op("post-reset 100/7", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_iterative.md
Name: div_iterative

Overview:
- Iterative restoring integer divider: the inverse of the ALU multiplier. Produces quotient and remainder of A / B, signed or unsigned.
- One quotient bit per cycle, with a start/done handshake.
- Sits beside the multiplier in the ALU datapath. It also serves as a standalone multi-cycle unit for the divide instructions.

Parameters:
- WORD_WIDTH, 36, operand/result width in bits; must be >= 2.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request a divide; honoured only when busy=0.
- sign  input  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start.
- A  input  WORD_WIDTH  dividend; sampled with start.
- B  input  WORD_WIDTH  divisor; sampled with start.
- busy  output  1  high while a divide is in progress.
- done  output  1  one-cycle pulse; Q, R, div_by_zero valid in this cycle.
- Q  output  WORD_WIDTH  quotient; held until the next done.
- R  output  WORD_WIDTH  remainder; held until the next done.
- div_by_zero  output  1  valid with done; held with Q/R.

Behaviour:
- Reset (synchronous, any state, including mid-divide):
  - Aborts any divide and goes to IDLE.
  - busy=0, done=0, Q=0, R=0, div_by_zero=0.
  - No done is produced for an aborted operation.
- States: IDLE, RUN, FIX.
  - IDLE: start=1 at cycle t latches A, B, sign and goes to RUN at t+1. If start=0, stay in IDLE.
  - RUN: lasts exactly WORD_WIDTH cycles (t+1..t+WORD_WIDTH), driven by an internal down-counter. Then FIX at t+WORD_WIDTH+1.
  - FIX: one cycle, then IDLE. Q, R and div_by_zero are registered and done=1 in cycle t+WORD_WIDTH+2.
- Fixed latency from start to done is WORD_WIDTH+2 cycles, independent of operand values and of divide-by-zero.
- busy=1 in cycles t+1..t+WORD_WIDTH+1; busy=0 in the done cycle.
- Start accepted in the done cycle: a new operation begins (back-to-back).
- Start while busy=1 is ignored. It is not queued, and operands are not re-sampled.
- Operand conditioning at latch time:
  - If sign=1, store |A| and |B| as unsigned WORD_WIDTH-bit magnitudes.
  - Store qneg = A[msb] XOR B[msb] and rneg = A[msb].
  - |most-negative| = 2^(WORD_WIDTH-1) and fits the unsigned magnitude.
  - If sign=0, store the operands as-is with qneg = rneg = 0.
- RUN, each cycle:
  - Shift the partial remainder left by 1, taking the next dividend bit (MSB first).
  - Trial subtract the divisor magnitude using a WORD_WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
- FIX, normal case:
  - Q = qneg ? -q : q; R = rneg ? -r : r.
  - Signed results truncate toward zero; the remainder takes the dividend's sign.
- FIX, divide by zero (latched B == 0): Q = all ones, R = original A (unmodified), div_by_zero=1. Otherwise div_by_zero=0.
- FIX, signed overflow (most-negative / -1): Q = most-negative (wraps), R = 0, div_by_zero=0. No other flag is raised.
- done is high for exactly one cycle per accepted start. Outputs do not change between done pulses.

Test Plan (bench uses WORD_WIDTH=8, so latency is 10):
- sign=0, A=200, B=7, start at t -> done only at t+10; Q=28, R=4, div_by_zero=0; busy high t+1..t+9.
- sign=1, A=0xF9 (-7), B=0x02 -> Q=0xFD (-3), R=0xFF (-1). Then A=0x07, B=0xFE (-2) -> Q=0xFD, R=0x01.
- Divide by zero: A=0x55, B=0x00, sign=0 and again with sign=1 -> Q=0xFF, R=0x55, div_by_zero=1 at t+10 both times.
- Overflow: sign=1, A=0x80, B=0xFF -> Q=0x80, R=0x00, div_by_zero=0. Also sign=0, A=0x80, B=0xFF -> Q=0x00, R=0x80.
- Handshake:
  - start held high with different operands during busy -> ignored; result matches the first operands.
  - start in the done cycle (A=9, B=3, unsigned) -> second done exactly 10 cycles later with Q=3, R=0.
- Reset at t+5 of a divide -> next cycle busy=0, done=0, Q=R=0; no done ever appears for that op. A fresh start after reset completes normally.
